// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU with valid/ready handshakes on both sides.
// Logic/add/sub/slt complete in one cycle. mul (shift-add) and divu (restoring)
// iterate one bit per cycle.
module seq_alu #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [WIDTH-1:0] data1_i,
   input  logic [WIDTH-1:0] data2_i,
   input  logic [2:0]       ALUCtrl_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] data_o,
   output logic             zero_o,
   output logic             div0_o,
   output logic             busy_o
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_XOR  = 3'b001;
   localparam logic [2:0] OP_SUB  = 3'b010;
   localparam logic [2:0] OP_SLT  = 3'b011;
   localparam logic [2:0] OP_AND  = 3'b100;
   localparam logic [2:0] OP_OR   = 3'b101;
   localparam logic [2:0] OP_DIVU = 3'b110;
   localparam logic [2:0] OP_MUL  = 3'b111;

   state_t             state_q;
   logic [WIDTH-1:0]   a_q;          // mul: shifting multiplicand; divu: dividend -> quotient
   logic [WIDTH-1:0]   b_q;          // mul: shifting multiplier;   divu: divisor
   logic [WIDTH-1:0]   acc_q;
   logic [WIDTH:0]     rem_q;
   logic [CNT_W-1:0]   count_q;
   logic               is_div_q;
   logic               div0_pend_q;
   logic               out_valid_q;
   logic [WIDTH-1:0]   data_q;
   logic               zero_q;
   logic               div0_q;

   logic               accept_c;
   logic               is_iter_c;
   logic [WIDTH-1:0]   alu_d;
   logic [WIDTH-1:0]   acc_d;
   logic [WIDTH+1:0]   rem_sh_d;
   logic [WIDTH+1:0]   rem_diff_d;
   logic               div_ok_d;
   logic [WIDTH:0]     rem_d;
   logic [WIDTH-1:0]   quo_d;

   assign in_ready_o  = (state_q == IDLE) || ((state_q == DONE) && out_ready_i);
   assign accept_c    = in_valid_i && in_ready_o;
   assign is_iter_c   = (ALUCtrl_i == OP_DIVU) || (ALUCtrl_i == OP_MUL);
   assign busy_o      = (state_q == BUSY);
   assign out_valid_o = out_valid_q;
   assign data_o      = data_q;
   assign zero_o      = zero_q;
   assign div0_o      = div0_q;

   // Single-cycle result straight from the input operands
   always_comb begin
      alu_d = '0;
      case (ALUCtrl_i)
         OP_ADD:  alu_d = data1_i + data2_i;
         OP_XOR:  alu_d = data1_i ^ data2_i;
         OP_SUB:  alu_d = data1_i - data2_i;
         OP_SLT:  alu_d = WIDTH'($signed(data1_i) < $signed(data2_i));
         OP_AND:  alu_d = data1_i & data2_i;
         OP_OR:   alu_d = data1_i | data2_i;
         default: alu_d = '0;
      endcase
   end

   // One shift-add step and one restoring-division step
   always_comb begin
      acc_d      = b_q[0] ? (acc_q + a_q) : acc_q;
      rem_sh_d   = {rem_q, a_q[WIDTH-1]};
      rem_diff_d = rem_sh_d - {2'b00, b_q};
      div_ok_d   = ~rem_diff_d[WIDTH+1];
      rem_d      = div_ok_d ? rem_diff_d[WIDTH:0] : rem_sh_d[WIDTH:0];
      quo_d      = {a_q[WIDTH-2:0], div_ok_d};
   end

   // Control FSM and datapath registers
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q     <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         acc_q       <= '0;
         rem_q       <= '0;
         count_q     <= '0;
         is_div_q    <= 1'b0;
         div0_pend_q <= 1'b0;
         out_valid_q <= 1'b0;
         data_q      <= '0;
         zero_q      <= 1'b0;
         div0_q      <= 1'b0;
      end else if (accept_c) begin
         if (is_iter_c) begin
            state_q     <= BUSY;
            a_q         <= data1_i;
            b_q         <= data2_i;
            acc_q       <= '0;
            rem_q       <= '0;
            count_q     <= CNT_W'(WIDTH);
            is_div_q    <= (ALUCtrl_i == OP_DIVU);
            div0_pend_q <= (ALUCtrl_i == OP_DIVU) && (data2_i == '0);
            out_valid_q <= 1'b0;
         end else begin
            state_q     <= DONE;
            data_q      <= alu_d;
            zero_q      <= (alu_d == '0);
            div0_q      <= 1'b0;
            out_valid_q <= 1'b1;
         end
      end else begin
         case (state_q)
            BUSY: begin
               if (count_q != '0) begin
                  count_q <= count_q - CNT_W'(1);
                  if (is_div_q) begin
                     rem_q <= rem_d;
                     a_q   <= quo_d;
                  end else begin
                     acc_q <= acc_d;
                     a_q   <= {a_q[WIDTH-2:0], 1'b0};
                     b_q   <= {1'b0, b_q[WIDTH-1:1]};
                  end
               end else begin
                  state_q     <= DONE;
                  data_q      <= is_div_q ? a_q : acc_q;
                  zero_q      <= (is_div_q ? a_q : acc_q) == '0;
                  div0_q      <= div0_pend_q;
                  out_valid_q <= 1'b1;
               end
            end
            DONE: begin
               if (out_ready_i) begin
                  state_q     <= IDLE;
                  out_valid_q <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: expected results queued at accept, checked at output handshake.
module tb_seq_alu;

   localparam int unsigned W = 32;

   logic          clk;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  d1;
   logic [W-1:0]  d2;
   logic [2:0]    op;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  dout;
   logic          zero;
   logic          div0;
   logic          busy;

   typedef struct {
      logic [W-1:0] data;
      logic         zero;
      logic         div0;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   seq_alu #(.WIDTH(W)) dut (
      .clk_i       (clk),
      .rst_n_i     (rst_n),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .data1_i     (d1),
      .data2_i     (d2),
      .ALUCtrl_i   (op),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .data_o      (dout),
      .zero_o      (zero),
      .div0_o      (div0),
      .busy_o      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
   endtask

   function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t e;
      logic [2*W-1:0] p;
      e.div0 = 1'b0;
      case (o)
         3'b000: e.data = a + b;
         3'b001: e.data = a ^ b;
         3'b010: e.data = a - b;
         3'b011: e.data = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         3'b100: e.data = a & b;
         3'b101: e.data = a | b;
         3'b110: begin
            if (b == 0) begin
               e.data = '1;
               e.div0 = 1'b1;
            end else e.data = a / b;
         end
         default: begin
            p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
            e.data = p[W-1:0];
         end
      endcase
      e.zero = (e.data == 0);
      return e;
   endfunction

   // Drive one request (call at a negedge); returns at the negedge after it is accepted
   task automatic send(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      int n;
      op = o; d1 = a; d2 = b; in_valid = 1'b1;
      n = 0;
      #1;
      while (!in_ready && n < 200) begin
         @(negedge clk); #1;
         n++;
      end
      if (n >= 200) check_eq("accept_timeout", 0, 1);
      sb.push_back(model(o, a, b));
      @(negedge clk);
      in_valid = 1'b0;
      d1 = $urandom; d2 = $urandom;
   endtask

   // Count clock edges after the accept edge until out_valid rises
   task automatic wait_valid(output int n, input bit chk_busy);
      n = 0;
      #1;
      while (!out_valid && n < 100) begin
         if (chk_busy) begin
            check_eq("busy_during_iter", busy, 1);
            check_eq("in_ready_during_iter", in_ready, 0);
         end
         @(negedge clk); #1;
         n++;
      end
      if (n >= 100) check_eq("valid_timeout", 0, 1);
   endtask

   // Output monitor: pop and compare on every completed output handshake
   initial begin
      exp_t e;
      forever begin
         @(negedge clk); #2;
         if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) check_eq("spurious_result", dout, 32'hDEAD_BEEF);
            else begin
               e = sb.pop_front();
               check_eq("data", dout, e.data);
               check_eq("zero", zero, e.zero);
               check_eq("div0", div0, e.div0);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic [2:0] ro;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      op = '0; d1 = '0; d2 = '0;
      repeat (3) @(negedge clk);
      check_eq("rst_out_valid", out_valid, 0);
      check_eq("rst_data", dout, 0);
      check_eq("rst_zero", zero, 0);
      check_eq("rst_div0", div0, 0);
      check_eq("rst_busy", busy, 0);
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("ready_after_rst", in_ready, 1);

      // add wrapping to zero, latency 1
      send(3'b000, 32'hFFFF_FFFF, 32'd1);
      wait_valid(n, 1'b0);
      check_eq("add_latency", n, 0);
      @(negedge clk);

      // back-to-back single-cycle ops
      send(3'b010, 32'd5, 32'd7);
      #1 check_eq("b2b_ready1", in_ready, 1);
      send(3'b011, 32'hFFFF_FFFE, 32'd1);
      #1 check_eq("b2b_ready2", in_ready, 1);
      send(3'b001, 32'h0000_F0F0, 32'h0000_0FF0);
      repeat (2) @(negedge clk);

      // mul latency and busy window
      send(3'b111, 32'h0001_0001, 32'h0001_0001);
      wait_valid(n, 1'b1);
      check_eq("mul_latency", n, W + 1);
      check_eq("busy_after_mul", busy, 0);
      @(negedge clk);

      // divu normal and divide-by-zero
      send(3'b110, 32'd100, 32'd7);
      wait_valid(n, 1'b1);
      check_eq("divu_latency", n, W + 1);
      @(negedge clk);
      send(3'b110, 32'd5, 32'd0);
      wait_valid(n, 1'b1);
      check_eq("div0_latency", n, W + 1);
      @(negedge clk);

      // backpressure: result held, next request stalled
      out_ready = 1'b0;
      send(3'b000, 32'd3, 32'd4);
      op = 3'b000; d1 = 32'd10; d2 = 32'd20; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         check_eq("bp_valid", out_valid, 1);
         check_eq("bp_data", dout, 32'd7);
         check_eq("bp_ready", in_ready, 0);
         @(negedge clk);
      end
      sb.push_back(model(3'b000, 32'd10, 32'd20));
      out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      #1 check_eq("bp_next_valid", out_valid, 1);
      @(negedge clk);

      // random mix, including requests held while busy
      for (int i = 0; i < 12; i++) begin
         ro = 3'($urandom_range(0, 7));
         send(ro, $urandom, (i == 5) ? 32'd0 : 32'($urandom_range(0, 255)));
      end
      repeat (40) @(negedge clk);

      // reset in the middle of a mul
      send(3'b111, 32'd3, 32'd5);
      repeat (10) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_eq("midrst_valid", out_valid, 0);
      check_eq("midrst_data", dout, 0);
      check_eq("midrst_busy", busy, 0);
      check_eq("midrst_div0", div0, 0);
      check_eq("midrst_zero", zero, 0);
      sb.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      send(3'b000, 32'd1, 32'd1);
      wait_valid(n, 1'b0);
      check_eq("post_rst_latency", n, 0);
      repeat (45) @(negedge clk);
      check_eq("sb_empty", sb.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
